ir_cmd_scheduler: RTL

- Bus-mapped command sequencer for the IR car transmitter.
- CPU queues {command byte, duration} entries into a small FIFO. The block applies each command byte to the transmitter config port for exactly N packet periods, then advances to the next entry.
- All command changes are aligned to the packet-start tick, so no packet is corrupted mid-flight.
- When the queue drains, the block reverts to the idle command (COMMAND 0000, last car type).

---
 rtl/ir_sched_pkg.sv | 32 +++
 rtl/ir_cmd_fifo.sv | 61 ++++++
 rtl/ir_cmd_scheduler.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/ir_sched_pkg.sv
// Shared definitions for the IR command scheduler: FSM states, register
// offsets, status bit positions and the reset command byte.
package ir_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    HOLD = 2'd2
  } sched_state_t;

  // Register offsets relative to BASE_ADDR
  localparam logic [7:0] OFS_CMD  = 8'd0;
  localparam logic [7:0] OFS_DUR  = 8'd1;
  localparam logic [7:0] OFS_CTRL = 8'd2;

  // Status byte layout {OVF, PAUSE, count[2:0], busy, full, empty}
  localparam int ST_EMPTY   = 0;
  localparam int ST_FULL    = 1;
  localparam int ST_BUSY    = 2;
  localparam int ST_CNT_LSB = 3;
  localparam int ST_PAUSE   = 6;
  localparam int ST_OVF     = 7;

  // Command byte presented after reset: COMMAND 0, car type 1
  localparam logic [7:0] RESET_CMD = 8'h01;

  // A zero duration still sends one packet
  function automatic logic [7:0] dur_clamp(input logic [7:0] dur);
    return (dur == 8'd0) ? 8'd1 : dur;
  endfunction

endpackage

// File: rtl/ir_cmd_fifo.sv
// Small synchronous FIFO holding {command, duration} entries. The head is
// read combinationally so the scheduler can apply it on the same edge that
// pops it. A push while full is ignored; the parent flags the overflow.
module ir_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  input  logic             flush,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count_reg == (AW+1)'(DEPTH));
  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rd_data = mem_reg[rd_ptr_reg];

  // Storage write; contents need no reset since count gates visibility
  always_ff @(posedge CLK) begin
    if (push_ok) mem_reg[wr_ptr_reg] <= wr_data;
  end

  // Pointer and occupancy bookkeeping; flush empties the queue at once
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + (AW+1)'(1);
        2'b01:   count_reg <= count_reg - (AW+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/ir_cmd_scheduler.sv
// Bus-mapped command sequencer for the IR car transmitter. Queued
// {command, duration} entries are applied to IR_CMD for a whole number of
// packet periods, always switching on PACKET_TICK.
// Optional build macro IR_SCHED_IRQ_EN adds the BUS_INTERRUPT_RAISE/ACK pair.
module ir_cmd_scheduler
  import ir_sched_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR  = 8'hA0,
  parameter int         FIFO_DEPTH = 4,
  parameter logic [3:0] IDLE_CMD   = 4'h0
) (
  input  logic       CLK,
  input  logic       RESET,
  inout  wire  [7:0] BUS_DATA,
  input  logic [7:0] BUS_ADDR,
  input  logic       BUS_WE,
  input  logic       PACKET_TICK,
  output logic [7:0] IR_CMD,
  output logic       IR_CMD_STB
`ifdef IR_SCHED_IRQ_EN
  ,
  output logic       BUS_INTERRUPT_RAISE,
  input  logic       BUS_INTERRUPT_ACK
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          wr_cmd, wr_dur, wr_ctrl, rd_status;
  logic          flush, ovf_event, can_pop;
  logic [7:0]    pend_cmd_reg;
  logic          pause_reg, ovf_reg;
  logic          fifo_full, fifo_empty, fifo_pop;
  logic [CW-1:0] fifo_count;
  logic [15:0]   fifo_head;
  logic [2:0]    status_cnt;
  logic [7:0]    status;

  sched_state_t  state_reg, state_next;
  logic [15:0]   staged_reg, staged_next;
  logic [7:0]    remaining_reg, remaining_next, rem_eff;
  logic [7:0]    ir_cmd_reg, ir_cmd_next;
  logic          stb_reg;

  assign wr_cmd    = BUS_WE && (BUS_ADDR == BASE_ADDR + OFS_CMD);
  assign wr_dur    = BUS_WE && (BUS_ADDR == BASE_ADDR + OFS_DUR);
  assign wr_ctrl   = BUS_WE && (BUS_ADDR == BASE_ADDR + OFS_CTRL);
  assign rd_status = !BUS_WE && (BUS_ADDR == BASE_ADDR + OFS_CTRL);
  assign flush     = wr_ctrl && BUS_DATA[0];
  assign ovf_event = wr_dur && fifo_full;
  // Flush takes priority so a flushed entry is never staged
  assign can_pop   = !fifo_empty && !pause_reg && !flush;

  ir_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (16)
  ) u_fifo (
    .CLK     (CLK),
    .RESET   (RESET),
    .push    (wr_dur),
    .wr_data ({pend_cmd_reg, BUS_DATA}),
    .pop     (fifo_pop),
    .rd_data (fifo_head),
    .flush   (flush),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // Status shows count[2:0]; small depths zero-extend, depth 16 truncates
  if (CW >= 3) begin : g_cnt_trunc
    assign status_cnt = fifo_count[2:0];
  end else begin : g_cnt_ext
    assign status_cnt = {{(3-CW){1'b0}}, fifo_count};
  end

  // Status byte assembled from registered state only
  always_comb begin
    status             = 8'h00;
    status[ST_OVF]     = ovf_reg;
    status[ST_PAUSE]   = pause_reg;
    status[ST_CNT_LSB +: 3] = status_cnt;
    status[ST_BUSY]    = (state_reg != IDLE);
    status[ST_FULL]    = fifo_full;
    status[ST_EMPTY]   = fifo_empty;
  end

  assign BUS_DATA = rd_status ? status : 8'hzz;

  // Bus-visible registers: staged command, pause level, sticky overflow
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      pend_cmd_reg <= RESET_CMD;
      pause_reg    <= 1'b0;
      ovf_reg      <= 1'b0;
    end else begin
      if (wr_cmd)  pend_cmd_reg <= BUS_DATA;
      if (wr_ctrl) pause_reg    <= BUS_DATA[1];
      if (flush)          ovf_reg <= 1'b0;
      else if (ovf_event) ovf_reg <= 1'b1;
    end
  end

  // Sequencer next-state: stage in IDLE, start in ARM, count packets in HOLD
  always_comb begin
    state_next     = state_reg;
    staged_next    = staged_reg;
    remaining_next = remaining_reg;
    ir_cmd_next    = ir_cmd_reg;
    fifo_pop       = 1'b0;
    rem_eff        = flush ? 8'd1 : remaining_reg;
    case (state_reg)
      IDLE: begin
        if (can_pop) begin
          fifo_pop    = 1'b1;
          staged_next = fifo_head;
          state_next  = ARM;
        end
      end
      ARM: begin
        if (flush) begin
          state_next = IDLE;
        end else if (PACKET_TICK) begin
          ir_cmd_next    = staged_reg[15:8];
          remaining_next = dur_clamp(staged_reg[7:0]);
          state_next     = HOLD;
        end
      end
      HOLD: begin
        if (PACKET_TICK) begin
          if (rem_eff > 8'd1) begin
            remaining_next = rem_eff - 8'd1;
          end else if (can_pop) begin
            // Chain straight into the next entry with no idle packet
            fifo_pop       = 1'b1;
            ir_cmd_next    = fifo_head[15:8];
            remaining_next = dur_clamp(fifo_head[7:0]);
          end else begin
            ir_cmd_next    = {IDLE_CMD, ir_cmd_reg[3:0]};
            remaining_next = 8'd0;
            state_next     = IDLE;
          end
        end else begin
          remaining_next = rem_eff;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Sequencer registers; strobe marks the cycle a new IR_CMD value appears
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_reg     <= IDLE;
      staged_reg    <= 16'h0000;
      remaining_reg <= 8'd0;
      ir_cmd_reg    <= RESET_CMD;
      stb_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      staged_reg    <= staged_next;
      remaining_reg <= remaining_next;
      ir_cmd_reg    <= ir_cmd_next;
      stb_reg       <= (ir_cmd_next != ir_cmd_reg);
    end
  end

  assign IR_CMD     = ir_cmd_reg;
  assign IR_CMD_STB = stb_reg;

`ifdef IR_SCHED_IRQ_EN
  logic irq_reg;
  logic hold_done;

  assign hold_done = (state_reg == HOLD) && (state_next == IDLE);

  // Interrupt latch: a new event outranks a simultaneous acknowledge
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)                       irq_reg <= 1'b0;
    else if (hold_done || ovf_event) irq_reg <= 1'b1;
    else if (BUS_INTERRUPT_ACK)      irq_reg <= 1'b0;
  end

  assign BUS_INTERRUPT_RAISE = irq_reg;
`endif

endmodule
